// File: rtl/mmio_store_responder.sv
// Memory-mapped store responder: stores to TXDATA are queued in a FIFO and drained
// over a valid/ready port. Loads return status, control and a drop counter combinationally.
module mmio_store_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    OFF_TXDATA  = 2'd0,
    OFF_STATUS  = 2'd1,
    OFF_CTRL    = 2'd2,
    OFF_DROPCNT = 2'd3
  } reg_off_e;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          en_q, en_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  reg_off_e      offset_s;
  logic          empty_s, full_s;
  logic          push_req_s, push_s, drop_s, pop_s;
  logic          ctrl_wr_s, dropcnt_wr_s;
  logic [31:0]   status_s;
  logic          unused_ok_s;

  assign offset_s    = reg_off_e'(DataAdr[3:2]);
  assign unused_ok_s = ^DataAdr[1:0];
  assign Hit         = (DataAdr[31:4] == BASE_ADDR[31:4]);

  assign empty_s   = (count_q == {CW{1'b0}});
  assign full_s    = (count_q == DEPTH_C);
  assign out_valid = en_q && !empty_s;
  assign out_data  = mem_q[rd_ptr_q];

  // Full is sampled before the edge, so a push into a full FIFO drops even if a pop happens too.
  assign pop_s  = out_valid && out_ready;
  assign push_s = push_req_s && !full_s;
  assign drop_s = push_req_s && full_s;

  // Write-strobe decode for the register window.
  always_comb begin
    push_req_s   = 1'b0;
    ctrl_wr_s    = 1'b0;
    dropcnt_wr_s = 1'b0;
    if (MemWrite && Hit) begin
      case (offset_s)
        OFF_TXDATA:  push_req_s   = 1'b1;
        OFF_CTRL:    ctrl_wr_s    = 1'b1;
        OFF_DROPCNT: dropcnt_wr_s = 1'b1;
        default:     push_req_s   = 1'b0;
      endcase
    end else begin
      push_req_s = 1'b0;
    end
  end

  // Load data mux; zero outside the window and for write-only or unused bits.
  always_comb begin
    status_s           = 32'h0000_0000;
    status_s[0]        = empty_s;
    status_s[1]        = full_s;
    status_s[7 +: CW]  = count_q;
    ReadData           = 32'h0000_0000;
    if (Hit) begin
      case (offset_s)
        OFF_TXDATA:  ReadData = 32'h0000_0000;
        OFF_STATUS:  ReadData = status_s;
        OFF_CTRL:    ReadData = {31'h0000_0000, en_q};
        OFF_DROPCNT: ReadData = {16'h0000, drop_cnt_q};
        default:     ReadData = 32'h0000_0000;
      endcase
    end else begin
      ReadData = 32'h0000_0000;
    end
  end

  // Next-state for pointers, occupancy, enable and the saturating drop counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    en_d       = en_q;
    drop_cnt_d = drop_cnt_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (ctrl_wr_s) begin
      en_d = WriteData[0];
    end else begin
      en_d = en_q;
    end

    if (dropcnt_wr_s) begin
      drop_cnt_d = 16'h0000;
    end else if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'h0001;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      en_q       <= 1'b0;
      drop_cnt_q <= 16'h0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      en_q       <= en_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // FIFO storage is not reset; out_data is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q] <= WriteData;
    end
  end

endmodule

// File: tb/tb_mmio_store_responder.sv
// Self-checking bench for mmio_store_responder: vector table plus scoreboard-modelled sequences.
module tb_mmio_store_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  mmio_store_responder #(.BASE_ADDR(32'h0000_0100), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sb[$];
  logic [31:0] emitted[$];
  logic        m_en = 1'b0;
  logic [15:0] m_drop = 16'h0000;

  logic [31:0] last_rd, last_data;
  logic        last_hit, last_valid;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rdy;
    logic        exp_hit;
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] adr);
    int sz = sb.size();
    logic [31:0] r = 32'h0;
    if (adr[31:4] == 28'h000_0010) begin
      case (adr[3:2])
        2'd1:    r = (32'(sz) << 7) | ((sz == 8) ? 32'h2 : 32'h0) | ((sz == 0) ? 32'h1 : 32'h0);
        2'd2:    r = {31'h0, m_en};
        2'd3:    r = {16'h0, m_drop};
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  // One bus cycle: drive, sample at negedge, compare against model, then advance model at the edge.
  task automatic cyc(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                     input logic rdy, input bit chk);
    logic exp_v, hit, pop, full;
    MemWrite = we; DataAdr = adr; WriteData = wd; out_ready = rdy;
    @(negedge clk);
    last_rd = ReadData; last_hit = Hit; last_valid = out_valid; last_data = out_data;
    exp_v = m_en && (sb.size() != 0);
    hit   = (adr[31:4] == 28'h000_0010);
    if (chk) begin
      check("out_valid", {31'h0, out_valid}, {31'h0, exp_v});
      if (exp_v) check("out_data", out_data, sb[0]);
      check("hit", {31'h0, Hit}, {31'h0, hit});
      check("read_data", ReadData, exp_read(adr));
    end
    if (out_valid && out_ready) emitted.push_back(out_data);
    if (reset) begin
      sb.delete(); m_en = 1'b0; m_drop = 16'h0000;
    end else begin
      pop  = exp_v && rdy;
      full = (sb.size() == 8);
      if (pop) void'(sb.pop_front());
      if (we && hit) begin
        case (adr[3:2])
          2'd0: begin
            if (!full) sb.push_back(wd);
            else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          end
          2'd2:    m_en = wd[0];
          2'd3:    m_drop = 16'h0000;
          default: ;
        endcase
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sb.size() != 0) cyc(1'b0, 32'h104, 32'h0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n55;
    tbl[0] = '{1'b0, 32'h104, 32'h0, 1'b1, 1'b1, 32'h1,   1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h10C, 32'h0, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'h100, 32'hA, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
    tbl[3] = '{1'b1, 32'h100, 32'hB, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
    tbl[4] = '{1'b1, 32'h108, 32'h1, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
    tbl[5] = '{1'b0, 32'h104, 32'h0, 1'b1, 1'b1, 32'h100, 1'b1, 32'hA};
    tbl[6] = '{1'b0, 32'h108, 32'h0, 1'b1, 1'b1, 32'h1,   1'b1, 32'hB};
    tbl[7] = '{1'b0, 32'h104, 32'h0, 1'b1, 1'b1, 32'h1,   1'b0, 32'h0};
    tbl[8] = '{1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};

    reset = 1'b1; MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0; out_ready = 1'b0;
    @(posedge clk); #1;
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;

    // Reset state and basic enable/drain, from the vector table.
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].rdy, 1'b1);
      check($sformatf("tbl%0d_hit", i), {31'h0, last_hit}, {31'h0, tbl[i].exp_hit});
      check($sformatf("tbl%0d_rd", i), last_rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_valid", i), {31'h0, last_valid}, {31'h0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_data", i), last_data, tbl[i].exp_data);
    end

    // Overfill with drain disabled.
    emitted.delete();
    cyc(1'b1, 32'h108, 32'h0, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) cyc(1'b1, 32'h100, 32'(k), 1'b0, 1'b1);
    cyc(1'b0, 32'h104, 32'h0, 1'b0, 1'b1);
    check("full_status", last_rd, 32'h0000_0402);
    cyc(1'b0, 32'h10C, 32'h0, 1'b0, 1'b1);
    check("dropcnt_2", last_rd, 32'h2);

    // Push into full FIFO while popping: push drops, pop proceeds.
    cyc(1'b1, 32'h108, 32'h1, 1'b0, 1'b1);
    cyc(1'b1, 32'h100, 32'h55, 1'b1, 1'b1);
    check("full_pop_valid", {31'h0, last_valid}, 32'h1);
    check("full_pop_data", last_data, 32'h1);
    cyc(1'b0, 32'h104, 32'h0, 1'b0, 1'b1);
    check("count7_status", last_rd, 32'h0000_0380);
    cyc(1'b0, 32'h10C, 32'h0, 1'b0, 1'b1);
    check("dropcnt_3", last_rd, 32'h3);
    drain(20);
    check("drain_len", 32'(emitted.size()), 32'd8);
    for (int i = 0; i < emitted.size(); i++) check($sformatf("drain_%0d", i), emitted[i], 32'(i + 1));
    n55 = 0;
    foreach (emitted[i]) if (emitted[i] == 32'h55) n55++;
    check("no_0x55", 32'(n55), 32'd0);

    // Streaming with toggling ready across pointer wrap.
    emitted.delete();
    for (int i = 0; i < 40; i++) cyc(i % 2 == 0, 32'h100, 32'd100 + 32'(i / 2), i % 2 == 0, 1'b1);
    drain(20);
    check("stream_len", 32'(emitted.size()), 32'd20);
    for (int i = 0; i < emitted.size(); i++) check($sformatf("stream_%0d", i), emitted[i], 32'd100 + 32'(i));
    cyc(1'b0, 32'h10C, 32'h0, 1'b0, 1'b1);
    check("dropcnt_kept", last_rd, 32'h3);
    cyc(1'b1, 32'h10C, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h10C, 32'h0, 1'b0, 1'b1);
    check("dropcnt_clr", last_rd, 32'h0);

    // Reset mid-transfer, then out-of-window and read-only stores.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100, 32'd200 + 32'(i), 1'b0, 1'b1);
    cyc(1'b0, 32'h104, 32'h0, 1'b0, 1'b1);
    check("pre_rst_valid", {31'h0, last_valid}, 32'h1);
    check("pre_rst_status", last_rd, 32'h0000_0280);
    reset = 1'b1;
    cyc(1'b0, 32'h104, 32'h0, 1'b1, 1'b1);
    reset = 1'b0;
    cyc(1'b0, 32'h104, 32'h0, 1'b1, 1'b1);
    check("rst_status", last_rd, 32'h1);
    check("rst_valid", {31'h0, last_valid}, 32'h0);
    cyc(1'b0, 32'h108, 32'h0, 1'b1, 1'b1);
    check("rst_en", last_rd, 32'h0);
    cyc(1'b1, 32'h200, 32'h1, 1'b1, 1'b1);
    check("miss_hit", {31'h0, last_hit}, 32'h0);
    check("miss_rd", last_rd, 32'h0);
    cyc(1'b1, 32'h208, 32'h1, 1'b1, 1'b1);
    cyc(1'b1, 32'h104, 32'hFFFF_FFFF, 1'b1, 1'b1);
    cyc(1'b0, 32'h104, 32'h0, 1'b1, 1'b1);
    check("after_miss_status", last_rd, 32'h1);
    cyc(1'b0, 32'h108, 32'h0, 1'b1, 1'b1);
    check("after_miss_en", last_rd, 32'h0);
    cyc(1'b0, 32'h10C, 32'h0, 1'b1, 1'b1);
    check("after_miss_drop", last_rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmio_store_responder.md
Name: mmio_store_responder

Overview:
- Memory-mapped responder on the processor data bus. It sits on the far side of the MemWrite / DataAdr / WriteData outputs of top.
- Stores to its TXDATA register are queued in a FIFO and drained to a downstream consumer over a valid/ready handshake.
- Loads from its register window return status and counters combinationally, as the single-cycle core requires.
- Sits beside data memory; the top-level address decode uses Hit to select ReadData.

Parameters:
- BASE_ADDR, 32'h0000_0100, word-aligned base of the 16-byte register window.
- DEPTH, 8, FIFO depth in 32-bit words; power of two, 2..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemWrite  input  1  store strobe from the core; one store per asserted cycle.
- DataAdr  input  32  byte address from the core.
- WriteData  input  32  store data from the core.
- ReadData  output  32  combinational load data for the addressed register.
- Hit  output  1  combinational; high when DataAdr[31:4] == BASE_ADDR[31:4].
- out_data  output  32  FIFO head word.
- out_valid  output  1  FIFO non-empty and drain enabled.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.

Behaviour:
- Register map, offset = DataAdr[3:0]; DataAdr[1:0] is ignored:
  - 0x0 TXDATA: write pushes WriteData; read returns 0.
  - 0x4 STATUS: read-only. bit0 empty, bit1 full, bits[7+:CW] count, rest 0. CW = $clog2(DEPTH)+1.
  - 0x8 CTRL: bit0 EN (drain enable), RW; other bits read 0.
  - 0xC DROPCNT: 16-bit saturating count of dropped pushes, zero-extended on read; any write clears it to 0.
- Reset (synchronous, takes priority over everything, including mid-transfer):
  - FIFO pointers and count = 0, EN = 0, DROPCNT = 0.
  - Results: out_valid = 0, STATUS reads empty = 1, full = 0.
  - FIFO contents are not cleared; out_data is don't-care while out_valid = 0.
- A write takes effect only when MemWrite && Hit, at the rising edge ending that cycle.
- Push (MemWrite && Hit && offset 0x0):
  - Accepted iff count < DEPTH at the start of the cycle.
  - If full, the word is dropped and DROPCNT increments (saturates at 16'hFFFF). No other state changes.
- Pop occurs when out_valid && out_ready:
  - The head advances and count decrements at the edge.
  - out_data shows the next word in the following cycle.
- Simultaneous push and pop:
  - Not full: both happen, count unchanged.
  - Full: the pop happens, the push is dropped and counted. Full status is sampled pre-edge.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Count ranges 0..DEPTH.
- out_valid = EN && (count != 0), combinational from registered state.
  - Clearing EN deasserts out_valid the next cycle; queued data is retained.
  - Pushes are accepted while EN = 0.
- Latency: a word pushed at edge N is visible on out_data / out_valid from cycle N+1, given EN = 1 and the FIFO previously empty.
- ReadData is purely combinational from DataAdr and current state. It is 0 when Hit = 0.
- Store with Hit = 0: ignored entirely.
- Store to a read-only offset (0x4): ignored.

Test Plan:
1. Reset held 3 cycles, then release -> out_valid = 0; load of 0x104 returns 32'h0000_0001 (empty, count 0); load of 0x10C returns 0.
2. Store 0x0000_000A, 0x0000_000B to 0x100 with EN = 0, then store 1 to 0x108, out_ready = 1 -> out_valid rises the cycle after the EN store; out_data shows 0xA then 0xB on consecutive cycles, then out_valid = 0.
3. EN = 0, store 10 words 1..10 to 0x100 (DEPTH = 8) -> STATUS = 32'h0000_0402 (full, count 8); DROPCNT = 2; after draining, out_data sequence is exactly 1..8.
4. FIFO full, same cycle: store 0x55 to 0x100 with out_ready = 1 and EN = 1 -> count = 7 after the edge; DROPCNT increments by 1; 0x55 is never emitted.
5. Stream 20 words with out_ready toggling 1,0,1,0 and EN = 1 -> all 20 words emerge in order, no loss, with pointer wrap exercised; then a store to 0x10C clears DROPCNT to 0.
6. Reset asserted with 5 words queued and out_valid = 1 -> after the edge, out_valid = 0, STATUS = 1, EN = 0; store to 0x200 (Hit = 0) leaves all state unchanged.
